// File: rtl/phys_free_list.sv
// ---------------------------------------------------------------------------
// phys_free_list
//
// Circular queue of free physical register tags. Rename pops up to SS new
// destination tags per cycle. The retired RAT pushes displaced mappings back,
// up to SS per cycle. On a flush the queue recovers to "every non-architectural
// tag is free" by moving head to CAP slots behind tail.
//
// Optional feature macro: FREE_LIST_CHECK_EN
//   defined   -> overflow pushes are dropped and set the sticky err flag (with
//                $error in simulation). A pop stall lasting 1024 consecutive
//                cycles also sets err (deadlock watchdog).
//   undefined -> err is tied to 0, no checks are made, and overflow is undefined.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   push_en    in   [SS]         per-way free request from the retired RAT
//   push_tag   in   [SS*PTAG_W]  tag to free, way i at [i*PTAG_W +: PTAG_W]
//   pop_req    in   [SS]         per-way tag request from rename
//   pop_tag    out  [SS*PTAG_W]  allocated tag per way, valid when pop_ready=1
//   pop_ready  out               every asserted pop_req can be granted
//   flush      in                mispredict/exception recovery
//   count      out  [PTR_W]      number of free entries
//   empty      out               count == 0
//   full       out               count == CAP
//   err        out               sticky overflow/watchdog flag
// ---------------------------------------------------------------------------
module phys_free_list #(
    parameter int SS        = 2,
    parameter int NUM_PREGS = 64,
    parameter int PTAG_W    = $clog2(NUM_PREGS),
    parameter int CAP       = NUM_PREGS - 32,
    parameter int PTR_W     = $clog2(CAP) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SS-1:0]        push_en,
    input  logic [SS*PTAG_W-1:0] push_tag,
    input  logic [SS-1:0]        pop_req,
    output logic [SS*PTAG_W-1:0] pop_tag,
    output logic                 pop_ready,
    input  logic                 flush,
    output logic [PTR_W-1:0]     count,
    output logic                 empty,
    output logic                 full,
    output logic                 err
);

    localparam int IDX_W = $clog2(CAP);

    // Index arithmetic relies on plain binary wrap of the pointers.
    generate
        if (CAP < 2 || (CAP & (CAP - 1)) != 0) begin : g_cap_check
            $fatal(1, "phys_free_list: CAP (%0d) must be a power of two", CAP);
        end
    endgenerate

    logic [PTAG_W-1:0] mem [CAP];
    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [PTR_W-1:0]  head_next;
    logic [PTR_W-1:0]  tail_next;
    logic [PTR_W-1:0]  npop;
    logic [PTR_W-1:0]  npush;
    logic [PTR_W-1:0]  popped;
    logic [PTR_W-1:0]  pop_off  [SS];
    logic [PTR_W-1:0]  push_off [SS];
    logic [SS-1:0]     push_ok;

    // The pointers carry one extra wrap bit. Their modular difference is
    // therefore the occupancy, even when count == CAP.
    assign count = tail_reg - head_reg;
    assign empty = (count == '0);
    assign full  = (count == PTR_W'(CAP));

    // ---------------------------------------------------------------------
    // Pop side: requesting ways are compacted onto consecutive slots from
    // head. An idle way previews the slot at its own position, so with no
    // requests the outputs show head, head+1, ...
    // ---------------------------------------------------------------------
    always_comb begin
        npop = '0;
        for (int i = 0; i < SS; i++) begin
            pop_off[i] = pop_req[i] ? npop : PTR_W'(i);
            npop       = npop + PTR_W'(pop_req[i]);
        end
    end

    // Only the pre-push count is used, so same-cycle frees never feed a pop.
    assign pop_ready = !flush && (count >= npop);
    assign popped    = pop_ready ? npop : '0;

    generate
        for (genvar gi = 0; gi < SS; gi++) begin : g_pop
            logic [PTR_W-1:0] rd_ptr;
            assign rd_ptr = head_reg + pop_off[gi];
            assign pop_tag[gi*PTAG_W +: PTAG_W] = mem[rd_ptr[IDX_W-1:0]];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Push side: enabled ways are compacted in way order onto tail, tail+1.
    // ---------------------------------------------------------------------
`ifdef FREE_LIST_CHECK_EN
    logic [PTR_W-1:0] room;
    logic             overflow;

    // Free slots left after this cycle's pops. A push beyond this would take
    // count above CAP.
    assign room = PTR_W'(CAP) - count + popped;
`endif

    always_comb begin
        npush = '0;
`ifdef FREE_LIST_CHECK_EN
        overflow = 1'b0;
`endif
        for (int i = 0; i < SS; i++) begin
            push_off[i] = npush;
            push_ok[i]  = push_en[i];
`ifdef FREE_LIST_CHECK_EN
            if (push_en[i] && (npush == room)) begin
                push_ok[i] = 1'b0;
                overflow   = 1'b1;
            end
`endif
            npush = npush + PTR_W'(push_ok[i]);
        end
    end

    assign tail_next = tail_reg + npush;

    // Flush: the CAP slots just behind the new tail hold exactly the tags
    // outside the retired RAT. Rewinding head there makes them all free again.
    assign head_next = flush ? (tail_next - PTR_W'(CAP)) : (head_reg + popped);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg <= '0;
            tail_reg <= PTR_W'(CAP);
            for (int i = 0; i < CAP; i++) begin
                mem[i] <= PTAG_W'(NUM_PREGS - CAP + i);
            end
        end else begin
            for (int i = 0; i < SS; i++) begin
                if (push_ok[i]) begin
                    mem[IDX_W'(tail_reg + push_off[i])] <= push_tag[i*PTAG_W +: PTAG_W];
                end
            end
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    logic       err_reg;
    logic [9:0] wd_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg    <= 1'b0;
            wd_cnt_reg <= '0;
        end else begin
            if (overflow) begin
                err_reg <= 1'b1;
                $error("phys_free_list: push overflow, excess way dropped");
            end
            // Count consecutive stalled cycles. The 1024th one raises err.
            if ((|pop_req) && !pop_ready) begin
                if (wd_cnt_reg == 10'd1023) begin
                    err_reg <= 1'b1;
                end else begin
                    wd_cnt_reg <= wd_cnt_reg + 10'd1;
                end
            end else begin
                wd_cnt_reg <= '0;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// ---------------------------------------------------------------------------
// tb_phys_free_list
//
// Self-checking bench for phys_free_list (SS=2, NUM_PREGS=64, CAP=32).
// The reference model is the complete history of tags entering the queue,
// held as a SV queue. It starts with 32..63, and each push appends in way
// order. A read index marks the next free tag. A flush moves the index to
// CAP entries before the end of the history.
// ---------------------------------------------------------------------------
module tb_phys_free_list;

    localparam int SS        = 2;
    localparam int NUM_PREGS = 64;
    localparam int PTAG_W    = 6;
    localparam int CAP       = 32;
    localparam int PTR_W     = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [SS-1:0]        push_en = '0;
    logic [SS*PTAG_W-1:0] push_tag = '0;
    logic [SS-1:0]        pop_req = '0;
    logic [SS*PTAG_W-1:0] pop_tag;
    logic                 pop_ready;
    logic                 flush = 1'b0;
    logic [PTR_W-1:0]     count;
    logic                 empty;
    logic                 full;
    logic                 err;

    always #5 clk = ~clk;

    phys_free_list #(
        .SS(SS),
        .NUM_PREGS(NUM_PREGS),
        .PTAG_W(PTAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push_en(push_en),
        .push_tag(push_tag),
        .pop_req(pop_req),
        .pop_tag(pop_tag),
        .pop_ready(pop_ready),
        .flush(flush),
        .count(count),
        .empty(empty),
        .full(full),
        .err(err)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model state
    int hist[$];
    int rd;
    bit m_err;

    typedef struct {
        logic [1:0] pe;
        logic [5:0] t0;
        logic [5:0] t1;
        logic [1:0] pr;
        logic       fl;
        logic       rdy;
        logic [5:0] e0;
        logic [5:0] e1;
        int         cnt;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pc2(input logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    function automatic int mcount();
        return hist.size() - rd;
    endfunction

    task automatic model_init();
        hist.delete();
        for (int i = 0; i < CAP; i++) hist.push_back(NUM_PREGS - CAP + i);
        rd    = 0;
        m_err = 1'b0;
    endtask

    task automatic check_state(input string pfx);
        chk({pfx, "_count"}, int'(count), mcount());
        chk({pfx, "_full"},  int'(full),  int'(mcount() == CAP));
        chk({pfx, "_empty"}, int'(empty), int'(mcount() == 0));
        chk({pfx, "_err"},   int'(err),   int'(m_err));
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        push_en  = '0;
        push_tag = '0;
        pop_req  = '0;
        flush    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_init();
        check_state("reset");
    endtask

    // One cycle: inputs are driven at a negedge. The combinational outputs are
    // checked just after, the edge is taken, and state is checked at the next
    // negedge. The DUT's pop_ready and pop_tag are returned for extra checks.
    task automatic apply(input logic [1:0] pe, input logic [5:0] t0, input logic [5:0] t1,
                         input logic [1:0] pr, input logic fl,
                         output logic rdy, output logic [5:0] g0, output logic [5:0] g1);
        int np;
        int k;
        bit exp_rdy;
        push_en  = pe;
        push_tag = {t1, t0};
        pop_req  = pr;
        flush    = fl;
        #1;
        np      = pc2(pr);
        exp_rdy = !fl && (mcount() >= np);
        rdy = pop_ready;
        g0  = pop_tag[5:0];
        g1  = pop_tag[11:6];
        chk("model_pop_ready", int'(pop_ready), int'(exp_rdy));
        if (exp_rdy) begin
            k = 0;
            if (pr[0]) begin
                chk("model_pop_tag0", int'(g0), hist[rd + k]);
                k++;
            end
            if (pr[1]) begin
                chk("model_pop_tag1", int'(g1), hist[rd + k]);
            end
        end
        @(posedge clk);
        if (exp_rdy) rd += np;
        if (pe[0]) hist.push_back(int'(t0));
        if (pe[1]) hist.push_back(int'(t1));
        if (fl) rd = hist.size() - CAP;
        @(negedge clk);
        push_en = '0;
        pop_req = '0;
        flush   = 1'b0;
        txn++;
        $display("txn %0d: pe=%b tags=%0d/%0d pr=%b fl=%b ready=%b grant=%0d/%0d count=%0d",
                 txn, pe, t0, t1, pr, fl, rdy, g0, g1, count);
        check_state("model");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       r;
        logic [5:0] g0;
        logic [5:0] g1;
        logic [1:0] pe;
        logic [1:0] pr;
        logic       fl;
        int         np;
        int         room;
        bit         rdy_m;

        // ---------------- reset state and idle preview ----------------
        @(negedge clk);
        do_reset();
        pop_req = 2'b00;
        #1;
        chk("idle_pop_tag0", int'(pop_tag[5:0]), 32);
        chk("idle_pop_tag1", int'(pop_tag[11:6]), 33);
        chk("idle_pop_ready", int'(pop_ready), 1);
        @(negedge clk);

        // ---------------- table-driven vectors from reset ----------------
        tbl[0] = '{2'b00, 6'd0, 6'd0, 2'b11, 1'b0, 1'b1, 6'd32, 6'd33, 30};
        tbl[1] = '{2'b00, 6'd0, 6'd0, 2'b11, 1'b0, 1'b1, 6'd34, 6'd35, 28};
        tbl[2] = '{2'b00, 6'd0, 6'd0, 2'b10, 1'b0, 1'b1, 6'd0,  6'd36, 27};
        tbl[3] = '{2'b01, 6'd7, 6'd0, 2'b00, 1'b0, 1'b1, 6'd0,  6'd0,  28};
        tbl[4] = '{2'b11, 6'd8, 6'd9, 2'b11, 1'b0, 1'b1, 6'd37, 6'd38, 28};
        tbl[5] = '{2'b00, 6'd0, 6'd0, 2'b01, 1'b0, 1'b1, 6'd39, 6'd0,  27};
        for (int i = 0; i < 6; i++) begin
            apply(tbl[i].pe, tbl[i].t0, tbl[i].t1, tbl[i].pr, tbl[i].fl, r, g0, g1);
            chk($sformatf("tbl%0d_ready", i), int'(r), int'(tbl[i].rdy));
            if (tbl[i].pr[0]) chk($sformatf("tbl%0d_tag0", i), int'(g0), int'(tbl[i].e0));
            if (tbl[i].pr[1]) chk($sformatf("tbl%0d_tag1", i), int'(g1), int'(tbl[i].e1));
            chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
        end
        chk("tbl_not_full", int'(full), 0);

        // ---------------- asynchronous reset mid-operation ----------------
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 32);
        chk("async_rst_full", int'(full), 1);
        @(negedge clk);
        rst = 1'b1;
        model_init();

        // ---------------- drain to 1, then an all-or-nothing stall ----------------
        do_reset();
        for (int i = 0; i < 15; i++) apply(2'b00, 6'd0, 6'd0, 2'b11, 1'b0, r, g0, g1);
        apply(2'b00, 6'd0, 6'd0, 2'b01, 1'b0, r, g0, g1);
        chk("drain_count", int'(count), 1);
        apply(2'b01, 6'd5, 6'd0, 2'b11, 1'b0, r, g0, g1);
        chk("stall_ready", int'(r), 0);
        chk("stall_count", int'(count), 2);
        apply(2'b00, 6'd0, 6'd0, 2'b11, 1'b0, r, g0, g1);
        chk("after_stall_ready", int'(r), 1);
        chk("after_stall_tag0", int'(g0), 63);
        chk("after_stall_tag1", int'(g1), 5);
        chk("after_stall_empty", int'(empty), 1);

        // ---------------- flush with a same-cycle push ----------------
        do_reset();
        apply(2'b00, 6'd0, 6'd0, 2'b11, 1'b0, r, g0, g1);
        apply(2'b00, 6'd0, 6'd0, 2'b11, 1'b0, r, g0, g1);
        apply(2'b11, 6'd3, 6'd9, 2'b00, 1'b0, r, g0, g1);
        apply(2'b01, 6'd12, 6'd0, 2'b11, 1'b1, r, g0, g1);
        chk("flush_ready", int'(r), 0);
        chk("flush_count", int'(count), 32);
        // tail is 35 after the flush, so head = 3; slots 3..6 still hold 35..38
        apply(2'b00, 6'd0, 6'd0, 2'b11, 1'b0, r, g0, g1);
        chk("flush_pop0", int'(g0), 35);
        chk("flush_pop1", int'(g1), 36);
        apply(2'b00, 6'd0, 6'd0, 2'b11, 1'b0, r, g0, g1);
        chk("flush_pop2", int'(g0), 37);
        chk("flush_pop3", int'(g1), 38);

        // ---------------- randomized traffic against the model ----------------
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n < 300) begin
                pr = 2'($urandom_range(0, 3));
                pe = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
                fl = ($urandom_range(0, 127) == 0);
            end else begin
                pr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
                pe = 2'($urandom_range(0, 3));
                fl = ($urandom_range(0, 31) == 0);
            end
            // Keep occupancy legal, because overflow is not defined behaviour.
            np    = pc2(pr);
            rdy_m = !fl && (mcount() >= np);
            room  = CAP - (mcount() - (rdy_m ? np : 0));
            if (pc2(pe) > room) pe = (room <= 0) ? 2'b00 : 2'b01;
            apply(pe, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), pr, fl, r, g0, g1);
        end

`ifdef FREE_LIST_CHECK_EN
        // ---------------- overflow at full ----------------
        do_reset();
        push_en  = 2'b11;
        push_tag = {6'd1, 6'd2};
        @(posedge clk);
        @(negedge clk);
        push_en = 2'b00;
        chk("ovf_err", int'(err), 1);
        chk("ovf_count", int'(count), 32);
        @(negedge clk);
        chk("ovf_err_sticky", int'(err), 1);
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
